reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Upstream reset-generation stage for the synchronous active-low register blocks in this design. Takes a raw asynchronous active-high reset and a software reset request. Produces per-stage synchronous active-low resets (`rst_n_out`) that:
- assert immediately on reset;
- stay asserted for a programmable hold time;
- release one stage at a time, in order, with a fixed gap between stages.

Each `rst_n_out` bit drives the `rst_n` input of one downstream synchronous block.

Parameters:
- SYNC_STAGES, 2: flops in the reset-release synchronizer chain; legal range >= 2.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after a synchronized release or an accepted soft request; legal range >= 1.
- NUM_OUTS, 3: number of sequenced active-low reset outputs; legal range >= 1.
- STAGE_GAP, 4: cycles between release of consecutive outputs; legal range >= 1.

Ports:
- clk, input, 1: single clock; all logic is on posedge.
- rst, input, 1: asynchronous active-high reset; clears every flop immediately.
- soft_rst_req, input, 1: software reset request, synchronous to clk; rising edge accepted only in RUN.
- rst_n_out, output, NUM_OUTS: synchronous active-low resets; bit 0 is released first.
- ready, output, 1: high when all outputs are released (state RUN).
- soft_rst_ack, output, 1: one-cycle pulse when a soft-initiated sequence completes.
- state, output, 2: debug; ASSERT=0, HOLD=1, RELEASE=2, RUN=3.

Behaviour:
- Reset is one clock, asynchronous active-high. While rst=1, every flop is cleared:
  - rst_n_out=0 (all bits), ready=0, soft_rst_ack=0, state=ASSERT;
  - synchronizer chain=0, counter=0, stage index=0, soft_rst_req history flop=0.
- Synchronizer:
  - The chain shifts in 1 each posedge once rst=0.
  - Its last stage (`synced`) reaches 1 at edge SYNC_STAGES, counting edges after rst deasserts as 1, 2, ...
  - Outputs must never deassert directly off rst; only the FSM drives them.
- ASSERT: on the first edge at which synced=1 (edge SYNC_STAGES+1), go to HOLD with counter=0.
- HOLD:
  - Counter increments each edge.
  - On the edge where counter==HOLD_CYCLES-1: set rst_n_out[0]=1, stage index=0, counter=0, go to RELEASE.
  - With NUM_OUTS=1, go straight to RUN instead (see the RELEASE exit rule).
- RELEASE:
  - Counter increments each edge.
  - On the edge where counter==STAGE_GAP-1: index increments, rst_n_out[index]=1, counter=0.
  - On the edge that releases bit NUM_OUTS-1: go to RUN and set ready=1 on that same edge.
- Release timing after power-up:
  - E0 = SYNC_STAGES+1+HOLD_CYCLES.
  - Bit k goes high at edge E0 + k*STAGE_GAP.
  - ready goes high together with the last bit.
  - Released bits stay 1 until the next reset or soft request.
- Soft request edge detect: a registered copy of soft_rst_req; a request is accepted when req=1 and prev=0, sampled in RUN.
- RUN, on an accepted request at edge S:
  - All rst_n_out=0 and ready=0 at edge S.
  - Go to HOLD with counter=0; the synchronizer is not re-run.
  - Bits release at S+HOLD_CYCLES + k*STAGE_GAP.
- soft_rst_ack:
  - Goes high for exactly one cycle on the edge that re-enters RUN from a soft-initiated sequence.
  - Never pulses for the power-up sequence.
  - A "soft pending" flag, set on accept and cleared on ack, tracks this.
- Ignored requests:
  - Requests in ASSERT, HOLD or RELEASE are ignored; nothing is queued.
  - A level held high through completion is not re-accepted; a new 0->1 edge is required.
- rst asserted mid-sequence (any state) aborts immediately:
  - Outputs are cleared asynchronously.
  - On deassert, the full sequence restarts including synchronization.
  - A pending soft ack is discarded.
- Counter width is $clog2 of max(HOLD_CYCLES, STAGE_GAP) + 1. No wrap is permitted before the compare hits.
- All outputs are registered; there is no combinational path from rst or soft_rst_req to any output other than the asynchronous clear.

Test Plan:
- Defaults; rst held high 5 cycles, then released before edge 0 -> rst_n_out=3'b000 during reset; bit0=1 at edge 19, bit1=1 at 23, bit2=1 at 27; ready=1 at 27; soft_rst_ack stays 0; state=3.
- In RUN, soft_rst_req pulsed high for 1 cycle, sampled at edge S -> rst_n_out=3'b000 and ready=0 at S; bits release at S+16, S+20, S+24; soft_rst_ack=1 for exactly the cycle after S+24.
- soft_rst_req held high 100 cycles from RUN -> exactly one sequence and one ack; no second reset until req drops and rises again.
- rst asserted at edge 21 of power-up (bit0 already 1) -> rst_n_out=0 immediately (asynchronous, no clk edge needed), state=0; after release, bit0 again high 19 edges later.
- soft_rst_req rising edge during HOLD (edge 10) -> ignored: power-up timing unchanged (19/23/27); no ack.
- NUM_OUTS=1, HOLD_CYCLES=1, STAGE_GAP=1 -> rst_n_out=1 and ready=1 at edge 4; soft request at S -> release and ack at S+1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Generates sequenced synchronous active-low resets for downstream blocks.
//   A raw asynchronous reset (or an accepted software request) drives every
//   output low. The outputs are held low for HOLD_CYCLES and then released
//   one at a time, bit 0 first, STAGE_GAP cycles apart.
//
// Ports
//   clk          : clock, all logic on posedge
//   rst          : asynchronous active-high reset, clears every flop
//   soft_rst_req : software reset request, rising edge accepted only in RUN
//   rst_n_out    : per-stage active-low resets, bit 0 released first
//   ready        : high while all outputs are released (RUN)
//   soft_rst_ack : one-cycle pulse when a soft-initiated sequence completes
//   state        : debug view of the FSM (ASSERT=0 HOLD=1 RELEASE=2 RUN=3)
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUTS    = 3,
  parameter int STAGE_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                ready,
  output logic                soft_rst_ack,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int CMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTS - 1);

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  synced;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d, idx_nx;
  logic                  soft_prev_q;
  logic                  soft_pend_q, soft_pend_d;
  logic                  soft_edge;
  logic                  hold_done, gap_done, enter_run;
  logic [NUM_OUTS-1:0]   rst_n_q, rst_n_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;

  // Release synchronizer: outputs only ever rise through the FSM, so the
  // deassertion of rst is first re-timed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_prev_q <= 1'b0;
    end else begin
      soft_prev_q <= soft_rst_req;
    end
  end

  assign soft_edge = soft_rst_req & ~soft_prev_q;
  assign idx_nx    = idx_q + 1'b1;
  assign hold_done = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST);
  assign gap_done  = (state_q == ST_RELEASE) && (cnt_q == GAP_LAST);
  // With a single output the HOLD exit releases the only bit and goes
  // straight to RUN; otherwise RUN follows the release of the last bit.
  assign enter_run = (hold_done && (NUM_OUTS == 1)) ||
                     (gap_done && (idx_nx == IDX_LAST));

  // State register (with counter, stage index and soft-pending flag)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      soft_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      soft_pend_q <= soft_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    soft_pend_d = soft_pend_q;
    unique case (state_q)
      ST_ASSERT: begin
        if (synced) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (hold_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (NUM_OUTS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (gap_done) begin
          cnt_d = '0;
          idx_d = idx_nx;
          if (idx_nx == IDX_LAST) begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (soft_edge) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          soft_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
    if (enter_run) begin
      soft_pend_d = 1'b0;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        ready_d = 1'b0;
      end
      ST_HOLD: begin
        if (hold_done) begin
          rst_n_d[0] = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (gap_done) begin
          for (int unsigned i = 0; i < NUM_OUTS; i++) begin
            if (IW'(i) == idx_nx) begin
              rst_n_d[i] = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (soft_edge) begin
          rst_n_d = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
    if (enter_run) begin
      ready_d = 1'b1;
      ack_d   = soft_pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_n_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_n_out    = rst_n_q;
  assign ready        = ready_q;
  assign soft_rst_ack = ack_q;
  assign state        = state_q;

endmodule
